// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: two-master round-robin arbiter in front of the data_ram
// single read/write port (a/we/d/spo). A master holding lock keeps the port
// for up to MAX_BURST consecutive grants. Read data is registered one cycle
// after the grant.
// Optional build macro RAM_ARB_STATS_EN adds saturating conflict/grant counters.
//
// Handshake: a transfer happens in any cycle where mN_req and mN_gnt are both
// high. gnt is combinational from req and registered state. A requester holds
// req/addr/we/wdata stable until it sees gnt. Read data is returned with
// mN_rvalid high for exactly one cycle, one cycle after the grant.
module ram_port_arbiter #(
    parameter int ADDR_W    = 8,
    parameter int DATA_W    = 32,
    parameter int MAX_BURST = 4,
    localparam int BE_W     = DATA_W / 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              m0_req,
    input  logic              m0_lock,
    input  logic [BE_W-1:0]   m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_gnt,
    output logic              m0_rvalid,
    output logic [DATA_W-1:0] m0_rdata,
    input  logic              m1_req,
    input  logic              m1_lock,
    input  logic [BE_W-1:0]   m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_gnt,
    output logic              m1_rvalid,
    output logic [DATA_W-1:0] m1_rdata,
    output logic [ADDR_W-1:0] ram_a,
    output logic [BE_W-1:0]   ram_we,
    output logic [DATA_W-1:0] ram_d,
    input  logic [DATA_W-1:0] ram_spo
`ifdef RAM_ARB_STATS_EN
    ,
    output logic [15:0]       conflict_cnt,
    output logic [15:0]       m0_gnt_cnt,
    output logic [15:0]       m1_gnt_cnt
`endif
);

    localparam int CNT_W = $clog2(MAX_BURST + 1);

    localparam logic [1:0] OWN_NONE = 2'd0;
    localparam logic [1:0] OWN_M0   = 2'd1;
    localparam logic [1:0] OWN_M1   = 2'd2;

    logic [1:0]        owner;
    logic              last;
    logic [CNT_W-1:0]  burst_cnt;
    logic [ADDR_W-1:0] addr_q;

    logic              gnt_any;
    logic              gnt_lock;
    logic              run_cont;
    logic [CNT_W-1:0]  run_next;

    // Grant decision: a requesting lock owner wins outright, otherwise
    // round-robin against the last served master. Reset forces no grant.
    always_comb begin
        m0_gnt = 1'b0;
        m1_gnt = 1'b0;
        if (!rst_n) begin
            m0_gnt = 1'b0;
        end else if (owner == OWN_M0 && m0_req) begin
            m0_gnt = 1'b1;
        end else if (owner == OWN_M1 && m1_req) begin
            m1_gnt = 1'b1;
        end else if (m0_req && m1_req) begin
            if (last) m0_gnt = 1'b1;
            else      m1_gnt = 1'b1;
        end else if (m0_req) begin
            m0_gnt = 1'b1;
        end else if (m1_req) begin
            m1_gnt = 1'b1;
        end
    end

    // Burst bookkeeping: a grant to the current owner extends the run,
    // any other locked grant starts a fresh run at 1.
    always_comb begin
        gnt_any  = m0_gnt | m1_gnt;
        gnt_lock = m0_gnt ? m0_lock : (m1_gnt & m1_lock);
        run_cont = (m0_gnt && owner == OWN_M0) || (m1_gnt && owner == OWN_M1);
        run_next = run_cont ? burst_cnt + CNT_W'(1) : CNT_W'(1);
    end

    // RAM port mux: the granted master drives the port; idle holds the address.
    always_comb begin
        ram_a  = addr_q;
        ram_we = '0;
        ram_d  = '0;
        if (m0_gnt) begin
            ram_a  = m0_addr;
            ram_we = m0_we;
            ram_d  = m0_wdata;
        end else if (m1_gnt) begin
            ram_a  = m1_addr;
            ram_we = m1_we;
            ram_d  = m1_wdata;
        end
    end

    // Arbitration state: owner, last-served master, burst length, held address.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner     <= OWN_NONE;
            last      <= 1'b1;
            burst_cnt <= '0;
            addr_q    <= '0;
        end else if (gnt_any) begin
            last   <= m1_gnt;
            addr_q <= ram_a;
            if (gnt_lock && run_next < CNT_W'(MAX_BURST)) begin
                owner     <= m0_gnt ? OWN_M0 : OWN_M1;
                burst_cnt <= run_next;
            end else begin
                owner     <= OWN_NONE;
                burst_cnt <= '0;
            end
        end else begin
            owner     <= OWN_NONE;
            burst_cnt <= '0;
        end
    end

    // Read response: capture spo at the granting edge, pulse rvalid next cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m0_rvalid <= 1'b0;
            m1_rvalid <= 1'b0;
            m0_rdata  <= '0;
            m1_rdata  <= '0;
        end else begin
            m0_rvalid <= m0_gnt && (m0_we == '0);
            m1_rvalid <= m1_gnt && (m1_we == '0);
            if (m0_gnt && m0_we == '0) m0_rdata <= ram_spo;
            if (m1_gnt && m1_we == '0) m1_rdata <= ram_spo;
        end
    end

`ifdef RAM_ARB_STATS_EN
    // Saturating statistics: cycles with both requests, grants per master.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            conflict_cnt <= '0;
            m0_gnt_cnt   <= '0;
            m1_gnt_cnt   <= '0;
        end else begin
            if (m0_req && m1_req && conflict_cnt != 16'hFFFF)
                conflict_cnt <= conflict_cnt + 16'd1;
            if (m0_gnt && m0_gnt_cnt != 16'hFFFF)
                m0_gnt_cnt <= m0_gnt_cnt + 16'd1;
            if (m1_gnt && m1_gnt_cnt != 16'hFFFF)
                m1_gnt_cnt <= m1_gnt_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: doc/ram_port_arbiter.md
Name: ram_port_arbiter

Overview:
- Two-master arbiter in front of the 256x32 data_ram single read/write port (a/we/d/spo), e.g. core load/store unit and DMA engine.
- Round-robin grant, optional locked bursts capped by MAX_BURST, registered read response one cycle after grant.
- The data_ram dual read port (dpra/dpo) is not owned by this block.

Parameters:
- ADDR_W, 8, RAM word-address width (256 words).
- DATA_W, 32, data width; byte-enable width BE_W = DATA_W/8.
- MAX_BURST, 4, maximum consecutive grants to one master while it holds lock (>=1).

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- m0_req  in  1  master 0 access request.
- m0_lock  in  1  master 0 requests to keep grant next cycle.
- m0_we  in  BE_W  master 0 byte write enables; 0 = read.
- m0_addr  in  ADDR_W  master 0 word address.
- m0_wdata  in  DATA_W  master 0 write data.
- m0_gnt  out  1  master 0 access accepted this cycle.
- m0_rvalid  out  1  master 0 read data valid (one cycle after granted read).
- m0_rdata  out  DATA_W  master 0 read data.
- m1_req, m1_lock, m1_we, m1_addr, m1_wdata, m1_gnt, m1_rvalid, m1_rdata  same as m0, master 1.
- ram_a  out  ADDR_W  to data_ram a.
- ram_we  out  BE_W  to data_ram we.
- ram_d  out  DATA_W  to data_ram d.
- ram_spo  in  DATA_W  from data_ram spo (asynchronous read).

Behaviour:
- Transfer = mN_req & mN_gnt in the same cycle. mN_gnt is combinational from req and registered state. At most one gnt high per cycle.
- RAM mux: granted master drives ram_a/ram_we/ram_d.
  - No grant: ram_we = 0, ram_a = last driven address (hold), ram_d = 0.
- Writes: commit at the granting clk edge with byte enables passed unmodified. Partial we (e.g. 4'b0001) updates only the enabled bytes.
- Reads (we == 0): ram_spo is captured into mN_rdata at the granting edge. mN_rvalid is high for exactly the following cycle.
  - mN_rdata holds its value until the next read to that master.
  - Granted writes produce no rvalid.
- State registers:
  - owner {NONE, M0, M1}: lock holder.
  - last: last-served master, 1 bit.
  - burst_cnt: 0..MAX_BURST, width clog2(MAX_BURST+1).
- Arbitration when owner == NONE:
  - Only one req: grant it.
  - Both req: grant !last.
  - None: no grant.
  - Every grant updates last.
- Lock rules:
  - Granted master with lock=1 sets owner to itself; burst_cnt counts grants in the run, 1 on the first.
  - While owner == N and mN_req=1: grant N regardless of the other master.
  - Owner releases to NONE when any of these hold: mN_lock=0 on a grant, mN_req=0, or burst_cnt reaches MAX_BURST.
  - On forced release at MAX_BURST, the other master wins the next cycle if requesting. If the other is idle, N may be re-granted and starts a new run with burst_cnt=1.
  - MAX_BURST=1 means lock has no effect beyond the single grant.
- Simultaneous: both masters requesting with lock, owner NONE → normal round-robin; only the winner's lock is honoured.
- Reset, also mid-burst or with rvalid pending:
  - owner=NONE, last=1 (so M0 wins first conflict), burst_cnt=0.
  - m0/m1_gnt=0, m0/m1_rvalid=0, m0/m1_rdata=0.
  - ram_we=0, ram_a=0, ram_d=0.
  - Pending read response is dropped.
- Requests are level; a master must hold req/addr/we/wdata stable until gnt.

Optional Feature:
- Macro RAM_ARB_STATS_EN.
- Defined: adds outputs conflict_cnt (16 bit), m0_gnt_cnt (16 bit), m1_gnt_cnt (16 bit).
  - conflict_cnt increments on each cycle both req are high.
  - mN_gnt_cnt increments on each mN grant.
  - All saturate at 16'hFFFF and reset to 0 on rst_n.
- Undefined: ports and counters absent; arbitration identical.

Test Plan:
- M0 writes 0xDEADBEEF to 0x00 (we=4'hF), then reads 0x00 → m0_gnt in request cycle, next cycle m0_rvalid=1, m0_rdata=0xDEADBEEF; m1 outputs idle.
- Both masters request reads every cycle, no lock, from reset → grants alternate M0,M1,M0,M1; M0 first; each rvalid one cycle after its grant.
- M1 writes 0xFFFFFFFF to 0x02, then we=4'b0001 with wdata 0x000000AA, then M0 reads 0x02 → m0_rdata=0xFFFFFFAA.
- M0 holds req+lock for 10 cycles while M1 requests continuously, MAX_BURST=4 → pattern M0x4, M1x1, M0x4, M1x1; M1 never waits >4 cycles.
- Assert rst_n=0 mid-burst, 1 cycle after a granted read → gnt, rvalid, ram_we drop to 0 asynchronously; after release the first conflict is granted to M0.
- With RAM_ARB_STATS_EN: 6 cycles both-request without lock → conflict_cnt=6, m0_gnt_cnt=3, m1_gnt_cnt=3.
